fft_peak_detect: RTL and testbench

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_peak_detect_if.sv | 30 +++
 rtl/fft_peak_detect.sv | 151 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detect_if.sv
// FFT bin stream in, per-frame peak result out.
// Master drives bins; slave publishes results.
interface fft_peak_detect_if #(
  parameter int W      = 16,
  parameter int N_BINS = 256
);
  localparam int IW = $clog2(N_BINS);

  logic                bin_valid;
  logic signed [W-1:0] bin_re;
  logic signed [W-1:0] bin_im;
  logic                bin_last;
  logic                peak_valid;
  logic [IW-1:0]       peak_bin;
  logic [W:0]          peak_mag;
  logic                peak_found;
  logic                frame_err;

  modport master (
    output bin_valid, bin_re, bin_im, bin_last,
    input  peak_valid, peak_bin, peak_mag,
    input  peak_found, frame_err
  );

  modport slave (
    input  bin_valid, bin_re, bin_im, bin_last,
    output peak_valid, peak_bin, peak_mag,
    output peak_found, frame_err
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Streaming FFT peak search: |z| approx, then
// a per-frame max over the positive-frequency half.
module fft_peak_detect #(
  parameter int W       = 16,
  parameter int N_BINS  = 256,
  parameter int MIN_BIN = 2,
  parameter int THRESH  = 64
) (
  input logic              clk,
  input logic              reset,
  fft_peak_detect_if.slave bus
);
  localparam int IW = $clog2(N_BINS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BINS - 1);
  localparam logic [IW-1:0] LO_IDX   = IW'(MIN_BIN);
  localparam logic [IW-1:0] HI_IDX   = IW'(N_BINS / 2 - 1);
  localparam logic signed [W-1:0] MOST_NEG =
    {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic {ACCUM, REPORT} state_t;
  state_t state, state_n;

  function automatic logic [W-1:0] sat_abs(
    input logic signed [W-1:0] x
  );
    if (x == MOST_NEG) return MAX_POS;
    if (x[W-1]) return W'(-x);
    return W'(x);
  endfunction

  logic [IW-1:0] idx;
  logic          in_err;

  // A bin flags an error if it closes a frame early/late
  // or if the index wraps without seeing bin_last.
  assign in_err = bus.bin_last ? (idx != LAST_IDX)
                               : (idx == LAST_IDX);

  // Input bin counter
  always_ff @(posedge clk) begin
    if (reset) idx <= '0;
    else if (bus.bin_valid) begin
      if (bus.bin_last || idx == LAST_IDX) idx <= '0;
      else idx <= idx + 1'b1;
    end
  end

  logic          s1_v, s1_last, s1_err;
  logic [IW-1:0] s1_idx;
  logic [W-1:0]  s1_re, s1_im;

  // Stage 1: saturating absolute values
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_err  <= 1'b0;
      s1_idx  <= '0;
      s1_re   <= '0;
      s1_im   <= '0;
    end else begin
      s1_v    <= bus.bin_valid;
      s1_last <= bus.bin_valid & bus.bin_last;
      s1_err  <= bus.bin_valid & in_err;
      s1_idx  <= idx;
      s1_re   <= sat_abs(bus.bin_re);
      s1_im   <= sat_abs(bus.bin_im);
    end
  end

  logic [W-1:0] mx, mn;
  assign mx = (s1_re > s1_im) ? s1_re : s1_im;
  assign mn = (s1_re > s1_im) ? s1_im : s1_re;

  logic          s2_v, s2_last, s2_err;
  logic [IW-1:0] s2_idx;
  logic [W:0]    s2_mag;

  // Stage 2: max + min/2 magnitude estimate
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_err  <= 1'b0;
      s2_idx  <= '0;
      s2_mag  <= '0;
    end else begin
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_err  <= s1_err;
      s2_idx  <= s1_idx;
      s2_mag  <= {1'b0, mx} + {2'b00, mn[W-1:1]};
    end
  end

  logic [W:0]    max_mag, cur_mag;
  logic [IW-1:0] max_bin, cur_bin;
  logic          err_acc, cur_err, take;

  assign take = s2_v && s2_idx >= LO_IDX &&
                s2_idx <= HI_IDX && s2_mag > max_mag;
  assign cur_mag = take ? s2_mag : max_mag;
  assign cur_bin = take ? s2_idx : max_bin;
  assign cur_err = err_acc | s2_err;

  // Stage 3: running max, published on the last bin
  always_ff @(posedge clk) begin
    if (reset) begin
      max_mag        <= '0;
      max_bin        <= LO_IDX;
      err_acc        <= 1'b0;
      bus.peak_bin   <= '0;
      bus.peak_mag   <= '0;
      bus.peak_found <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else if (s2_v) begin
      if (s2_last) begin
        bus.peak_bin   <= cur_bin;
        bus.peak_mag   <= cur_mag;
        bus.peak_found <= cur_mag >= (W+1)'(THRESH);
        bus.frame_err  <= cur_err;
        max_mag        <= '0;
        max_bin        <= LO_IDX;
        err_acc        <= 1'b0;
      end else begin
        max_mag <= cur_mag;
        max_bin <= cur_bin;
        err_acc <= cur_err;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else state <= state_n;
  end

  // Next state: report for one cycle per frame end
  always_comb begin
    state_n = ACCUM;
    unique case (state)
      ACCUM:   if (s2_v && s2_last) state_n = REPORT;
      REPORT:  state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  assign bus.peak_valid = (state == REPORT);
endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: directed frames plus
// random frames checked against a per-frame model.
module tb_fft_peak_detect;
  localparam int N = 256;

  typedef struct {
    int cyc;
    int bn;
    int mg;
    int fd;
    int er;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   fre[N];
  int   fim[N];
  res_t exp_q[$];
  res_t got_q[$];

  fft_peak_detect_if #(.W(16), .N_BINS(N)) bus ();

  fft_peak_detect #(
    .W(16), .N_BINS(N), .MIN_BIN(2), .THRESH(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t r;
    if (bus.peak_valid === 1'b1) begin
      r.cyc = cyc;
      r.bn  = int'(bus.peak_bin);
      r.mg  = int'(bus.peak_mag);
      r.fd  = int'(bus.peak_found);
      r.er  = int'(bus.frame_err);
      got_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input int obs,
                     input int want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  function automatic int mag_of(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.bin_valid = 1'b0;
      bus.bin_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input int len);
    res_t e;
    int   m;
    e.mg = 0;
    e.bn = 2;
    for (int i = 2; i < N / 2 && i < len; i++) begin
      m = mag_of(fre[i], fim[i]);
      if (m > e.mg) begin
        e.mg = m;
        e.bn = i;
      end
    end
    e.fd = (e.mg >= 64) ? 1 : 0;
    e.er = (len != N) ? 1 : 0;
    e.cyc = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      bus.bin_valid = 1'b1;
      bus.bin_re    = 16'(fre[i]);
      bus.bin_im    = 16'(fim[i]);
      bus.bin_last  = (i == len - 1);
      if (i == len - 1) e.cyc = cyc + 3;
    end
    exp_q.push_back(e);
  endtask

  task automatic check_results(input string tag);
    res_t g, e;
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ".cyc"},   g.cyc, e.cyc);
      chk({tag, ".bin"},   g.bn,  e.bn);
      chk({tag, ".mag"},   g.mg,  e.mg);
      chk({tag, ".found"}, g.fd,  e.fd);
      chk({tag, ".err"},   g.er,  e.er);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pv"},  int'(bus.peak_valid), 0);
    chk({tag, ".bin"}, int'(bus.peak_bin),   0);
    chk({tag, ".mag"}, int'(bus.peak_mag),   0);
    chk({tag, ".fd"},  int'(bus.peak_found), 0);
    chk({tag, ".err"}, int'(bus.frame_err),  0);
  endtask

  initial begin
    int len, pos;
    reset         = 1'b1;
    bus.bin_valid = 1'b0;
    bus.bin_re    = '0;
    bus.bin_im    = '0;
    bus.bin_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    clear_frame();
    fre[37] = 1000;
    send_frame(N);
    idle(6);
    check_results("tone");
    chk("hold.bin", int'(bus.peak_bin), 37);
    chk("hold.mag", int'(bus.peak_mag), 1000);

    clear_frame();
    fre[0]   = 30000;
    fre[200] = 30000;
    fre[10]  = -100;
    fim[10]  = -100;
    send_frame(N);
    idle(6);
    check_results("dcmirror");

    clear_frame();
    fre[20] = -32768;
    fre[21] = -32768;
    send_frame(N);
    idle(6);
    check_results("tiesat");

    clear_frame();
    fre[5] = 500;
    send_frame(N);
    clear_frame();
    fim[90] = -700;
    send_frame(N);
    idle(6);
    check_results("b2b");

    clear_frame();
    fre[50] = 400;
    send_frame(100);
    idle(6);
    check_results("short");

    for (int i = 0; i < N; i++) fre[i] = 40;
    send_frame(N);
    idle(6);
    check_results("lowthr");

    clear_frame();
    send_frame(1);
    idle(6);
    check_results("onebin");

    clear_frame();
    fre[60] = 9000;
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      bus.bin_valid = 1'b1;
      bus.bin_re    = 16'(fre[i]);
      bus.bin_im    = '0;
      bus.bin_last  = 1'b0;
    end
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.bin_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(6);
    chk("midrst.nopulse", got_q.size(), 0);
    got_q.delete();
    clear_frame();
    fre[77] = 2000;
    fim[77] = 1000;
    send_frame(N);
    idle(6);
    check_results("postrst");

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        fre[i] = int'($urandom_range(0, 120)) - 60;
        fim[i] = int'($urandom_range(0, 120)) - 60;
      end
      pos = int'($urandom_range(0, N - 1));
      fre[pos] = int'($urandom_range(0, 65535)) - 32768;
      fim[pos] = int'($urandom_range(0, 65535)) - 32768;
      len = ($urandom_range(0, 3) == 0) ?
            int'($urandom_range(1, N)) : N;
      send_frame(len);
    end
    idle(6);
    check_results("rand");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
